// File: rtl/rca_word_seq.sv
`default_nettype none
// ============================================================================
// Module   : rca_word_seq
// Brief    : Word-serial adder. One W-bit ripple-carry adder is reused once
//            per cycle to add two N-word operands, least significant word
//            first, with valid/ready handshakes on the input and output sides.
// Revision : 1.0 - initial release
// ============================================================================

// W-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_c;

  assign w_c[0]  = i_cin;
  assign o_cout  = w_c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

endmodule

// Sequencer around the shared adder: captures operands, walks the word index
// from 0 to N-1, then presents the result until the consumer takes it.
module rca_word_seq #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] a,
  input  logic [W*N-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*N-1:0] sum,
  output logic           cout,
  output logic           busy
);

  // Index wide enough to hold 0..N; it never exceeds N-1 in practice.
  localparam int KW = $clog2(N + 1);
  localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic [W*N-1:0]  r_a;
  logic [W*N-1:0]  r_b;
  logic [W*N-1:0]  r_sum;
  logic            r_cout;

  logic [W-1:0]    w_a_word;
  logic [W-1:0]    w_b_word;
  logic [W-1:0]    w_sum_word;
  logic            w_cout_word;

  // Select the current operand words for the shared adder.
  always_comb begin
    w_a_word = r_a[r_k*W +: W];
    w_b_word = r_b[r_k*W +: W];
  end

  ripple_carry #(
    .W (W)
  ) u_adder (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum_word),
    .o_cout (w_cout_word)
  );

  // Handshake and control sequencing; the result registers are written one
  // word per cycle, so untouched words keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_k     <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[r_k*W +: W] <= w_sum_word;
          r_carry           <= w_cout_word;
          if (r_k == C_K_LAST) begin
            // Last word: publish the carry-out and park the index at 0.
            r_cout  <= w_cout_word;
            r_k     <= '0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ADD);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_rca_word_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_word_seq
// Brief    : Directed bench for rca_word_seq (W=4,N=4 and W=8,N=1 instances)
//            with a queue of expected results consumed at out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_word_seq;

  logic        clk;
  logic        rst_n;

  // W=4, N=4 instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  // W=8, N=1 instance
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q  [$];
  logic [8:0]  exp8_q [$];

  rca_word_seq #(.W(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  rca_word_seq #(.W(8), .N(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input int hold_low, input bit toggle);
    logic [16:0] e;
    int edges;
    int busy_cnt;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {16'd0, tc});
    @(negedge clk);                     // accept edge has passed
    in_valid = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 20) begin
      if (busy) busy_cnt++;
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    chk("latency_edges", edges, 32'd4);
    chk("busy_cycles", busy_cnt, 32'd4);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
      chk("cout", {31'd0, cout}, {31'd0, e[16]});
      for (int i = 0; i < hold_low; i++) begin
        @(negedge clk);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_sum", {15'd0, cout, sum}, {15'd0, e});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);                     // DONE->IDLE edge has passed
    out_ready = 1'b0;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [8:0] e8;
    int edges8;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    #12;
    // Reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum_cout", {15'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;                       // accept on the first rising edge after release

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 3, 1'b0);
    run_op(16'h8F0E, 16'h70F1, 1'b1, 1, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b1);

    // Reset during ADD with k=2
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);                     // two ADD edges done, k == 2
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum_cout", {15'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hBEEF, 16'h4111, 1'b1, 2, 1'b0);

    // W=8, N=1 instance
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; in_valid8 = 1'b1;
    exp8_q.push_back({1'b0, 8'hFF} + {1'b0, 8'h01} + 9'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    edges8 = 0;
    while (!out_valid8 && edges8 < 10) begin
      @(negedge clk);
      edges8++;
    end
    chk("n1_latency_edges", edges8, 32'd1);
    e8 = exp8_q.pop_front();
    chk("n1_sum", {24'd0, sum8}, {24'd0, e8[7:0]});
    chk("n1_cout", {31'd0, cout8}, {31'd0, e8[8]});
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("n1_idle_in_ready", {31'd0, in_ready8}, 32'd1);

    chk("scoreboard_drained", exp_q.size() + exp8_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
